scan_mux: RTL and testbench

Parametrised, registered N:1 word selector with valid/ready handshake and an autonomous round-robin scan mode. It generalises the processor's fixed 32×32-bit combinational selector. It serves register/telemetry read-out paths, for example cycling servo-position or sensor words toward the arm controller, where the consumer may stall.

---
 rtl/scan_mux.sv | 93 +++++++++
 tb/tb_scan_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// scan_mux: registered NUM_IN:1 word selector with valid/ready handshake.
//
// In direct mode (mode = 0) a word is captured from channel req_sel whenever
// req_valid is high and the output slot is free. In scan mode (mode = 1) the
// block generates its own requests, walking channels 0..scan_last and
// flagging the wrap-point word with out_last.
//
// Ports:
//   clock      rising-edge clock for all state
//   resetn     synchronous active-low reset
//   in_data    flattened channels, channel k = in_data[k*WIDTH +: WIDTH]
//   mode       0 = direct requests, 1 = autonomous round-robin scan
//   scan_last  highest channel index visited in scan mode
//   req_valid  direct-mode request present
//   req_sel    direct-mode channel index
//   req_ready  direct-mode request accepted when high with req_valid
//   out_valid  out_* fields hold a captured word
//   out_ready  consumer takes the word when high with out_valid
//   out_data   captured channel word
//   out_sel    index of the captured channel
//   out_last   scan mode: captured index was the wrap point
module scan_mux #(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_IN = 32,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        scan_last,
    input  logic                    req_valid,
    input  logic [SEL_W-1:0]        req_sel,
    output logic                    req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last
);

    logic [WIDTH-1:0] chan [NUM_IN];
    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] sel;
    logic             slot_free;
    logic             accept;
    logic             wrap;

    // Unflatten the channel bus so the selector is a plain array index.
    always_comb begin
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            chan[k] = in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        slot_free = !out_valid || out_ready;
        accept    = slot_free && (mode || req_valid);
        sel       = mode ? scan_ptr : req_sel;
        // ">=" rather than "==" so a scan_last lowered below the pointer
        // still terminates the pass on the very next word.
        wrap      = (scan_ptr >= scan_last);
        req_ready = slot_free && !mode && resetn;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            scan_ptr  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= chan[sel];
                out_sel   <= sel;
                out_last  <= mode && wrap;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Pointer is parked at 0 in direct mode so every scan entry
            // starts from channel 0.
            if (!mode) begin
                scan_ptr <= '0;
            end else if (accept) begin
                scan_ptr <= wrap ? '0 : scan_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 32;
    localparam int unsigned SEL_W  = 5;

    logic                    clock;
    logic                    resetn;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    mode;
    logic [SEL_W-1:0]        scan_last;
    logic                    req_valid;
    logic [SEL_W-1:0]        req_sel;
    logic                    req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_last;

    int tests;
    int fails;

    scan_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_data   (in_data),
        .mode      (mode),
        .scan_last (scan_last),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Check a full captured word: valid, data, index and wrap flag.
    task automatic chk_word(input string tag, input logic [SEL_W-1:0] s,
                            input logic [WIDTH-1:0] d, input logic l);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".sel"},   64'(out_sel),   64'(s));
        chk({tag, ".last"},  64'(out_last),  64'(l));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        resetn    = 1'b0;
        mode      = 1'b0;
        scan_last = '0;
        req_valid = 1'b1;
        req_sel   = 5'd5;
        out_ready = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            in_data[k*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(k);
        end

        // Reset held for three cycles with a pending request.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst.valid", 64'(out_valid), 64'd0);
            chk("rst.data",  64'(out_data),  64'd0);
            chk("rst.ready", 64'(req_ready), 64'd0);
        end

        // Release; the pending request is accepted on the next edge.
        resetn = 1'b1;
        #1;
        chk("rel.ready", 64'(req_ready), 64'd1);

        // Direct back-to-back: 5, 31, 0.
        cyc();
        chk_word("d5", 5'd5, 32'hA000_0005, 1'b0);
        req_sel = 5'd31;
        cyc();
        chk_word("d31", 5'd31, 32'hA000_001F, 1'b0);
        req_sel = 5'd0;
        cyc();
        chk_word("d0", 5'd0, 32'hA000_0000, 1'b0);

        // Backpressure: capture 7, stall 4 cycles while channel 7 changes.
        req_sel = 5'd7;
        cyc();
        chk_word("d7", 5'd7, 32'hA000_0007, 1'b0);
        out_ready = 1'b0;
        req_sel   = 5'd9;
        for (int i = 0; i < 4; i++) begin
            in_data[7*WIDTH +: WIDTH] = 32'hDEAD_0000 + 32'(i);
            #1;
            chk("bp.ready", 64'(req_ready), 64'd0);
            cyc();
            chk_word("bp.hold", 5'd7, 32'hA000_0007, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rel.ready", 64'(req_ready), 64'd1);
        cyc();
        chk_word("d9", 5'd9, 32'hA000_0009, 1'b0);

        // Drain with no new request.
        req_valid = 1'b0;
        cyc();
        chk("drain.valid", 64'(out_valid), 64'd0);

        // Scan wrap with scan_last = 3.
        mode      = 1'b1;
        scan_last = 5'd3;
        req_valid = 1'b1;
        #1;
        chk("scan.ready", 64'(req_ready), 64'd0);
        cyc(); chk_word("s0", 5'd0, 32'hA000_0000, 1'b0);
        cyc(); chk_word("s1", 5'd1, 32'hA000_0001, 1'b0);
        cyc(); chk_word("s2", 5'd2, 32'hA000_0002, 1'b0);
        cyc(); chk_word("s3", 5'd3, 32'hA000_0003, 1'b1);
        chk("scan.ready2", 64'(req_ready), 64'd0);
        cyc(); chk_word("s0b", 5'd0, 32'hA000_0000, 1'b0);
        cyc(); chk_word("s1b", 5'd1, 32'hA000_0001, 1'b0);

        // Widen the range and advance to index 5.
        scan_last = 5'd31;
        cyc(); chk_word("s2c", 5'd2, 32'hA000_0002, 1'b0);
        cyc(); chk_word("s3c", 5'd3, 32'hA000_0003, 1'b0);
        cyc(); chk_word("s4c", 5'd4, 32'hA000_0004, 1'b0);
        cyc(); chk_word("s5c", 5'd5, 32'hA000_0005, 1'b0);

        // Stall at 5, then lower scan_last below the pointer.
        out_ready = 1'b0;
        cyc(); chk_word("st.h1", 5'd5, 32'hA000_0005, 1'b0);
        cyc(); chk_word("st.h2", 5'd5, 32'hA000_0005, 1'b0);
        scan_last = 5'd2;
        cyc(); chk_word("st.h3", 5'd5, 32'hA000_0005, 1'b0);
        out_ready = 1'b1;
        cyc(); chk_word("rt6", 5'd6, 32'hA000_0006, 1'b1);
        cyc(); chk_word("rt0", 5'd0, 32'hA000_0000, 1'b0);
        cyc(); chk_word("rt1", 5'd1, 32'hA000_0001, 1'b0);
        cyc(); chk_word("rt2", 5'd2, 32'hA000_0002, 1'b1);

        // Mode switch: advance past 0, drop to direct for one cycle, resume.
        scan_last = 5'd31;
        cyc(); chk_word("ms0", 5'd0, 32'hA000_0000, 1'b0);
        cyc(); chk_word("ms1", 5'd1, 32'hA000_0001, 1'b0);
        mode      = 1'b0;
        req_valid = 1'b0;
        cyc();
        chk("ms.drain", 64'(out_valid), 64'd0);
        mode = 1'b1;
        cyc(); chk_word("ms.r0", 5'd0, 32'hA000_0000, 1'b0);
        cyc(); chk_word("ms.r1", 5'd1, 32'hA000_0001, 1'b0);

        // Reset while a word is held.
        resetn = 1'b0;
        cyc();
        chk("mrst.valid", 64'(out_valid), 64'd0);
        chk("mrst.data",  64'(out_data),  64'd0);
        chk("mrst.sel",   64'(out_sel),   64'd0);
        chk("mrst.ready", 64'(req_ready), 64'd0);
        resetn = 1'b1;
        cyc(); chk_word("mrst.s0", 5'd0, 32'hA000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
